// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a FIFO: pops one byte per frame and serialises
// start, LSB-first data, optional even parity and stop bits on tx.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic                  tx_enable,
  input  logic                  empty,
  output logic                  read,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_PRE  = TW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  state_t                r_state;
  logic [TW-1:0]         r_timer;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_parity;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_frame_done;

  logic                  w_bit_end;
  logic                  w_can_pop;
  logic [DATA_WIDTH-1:0] w_shift_next;

  assign w_bit_end    = (r_timer == T_LAST);
  assign w_can_pop    = tx_enable & ~empty;
  assign w_shift_next = r_shift >> 1;

  assign read       = (r_state == S_POP);
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

  // Frame sequencer; tx is registered one state ahead so it changes with the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (clk_enable) begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_can_pop) begin
            r_state <= S_POP;
            r_busy  <= 1'b1;
          end
        end
        S_POP: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shift  <= read_data;
          r_parity <= even_parity(read_data);
          r_timer  <= '0;
          r_tx     <= 1'b0;
          r_state  <= S_START;
        end
        S_START: begin
          if (w_bit_end) begin
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_timer <= '0;
            if (r_bit_cnt == B_LAST) begin
              if (PARITY_EN) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_shift   <= w_shift_next;
              r_tx      <= w_shift_next[0];
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_timer <= '0;
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_timer <= '0;
            if (w_can_pop) begin
              r_state <= S_POP;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
            // Pulse lands on the final stop cycle because the output is registered
            if (r_timer == T_PRE) begin
              r_frame_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two instances (no parity / even parity)
// fed by small FIFO models, frames decoded and compared against a scoreboard.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_enable;
  logic tx_enable = 1'b1;
  logic toggle = 1'b0;

  logic       empty0, read0, tx0, busy0, fd0;
  logic [7:0] rdata0;
  logic       empty1, read1, tx1, busy1, fd1;
  logic [7:0] rdata1;

  logic [7:0] mem0 [0:63];
  logic [7:0] mem1 [0:63];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0, viol = 0;
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];

  int n_chk = 0;
  int n_pass = 0;

  assign empty0 = (wp0 == rp0);
  assign empty1 = (wp1 == rp1);

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) u_dut0 (
    .clk(clk), .reset(rst_n), .clk_enable(clk_enable), .tx_enable(tx_enable),
    .empty(empty0), .read(read0), .read_data(rdata0), .tx(tx0), .busy(busy0),
    .frame_done(fd0)
  );

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) u_dut1 (
    .clk(clk), .reset(rst_n), .clk_enable(clk_enable), .tx_enable(tx_enable),
    .empty(empty1), .read(read1), .read_data(rdata1), .tx(tx1), .busy(busy1),
    .frame_done(fd1)
  );

  always #5 clk = ~clk;

  initial begin
    clk_enable = 1'b1;
    forever begin
      @(negedge clk);
      clk_enable = toggle ? ~clk_enable : 1'b1;
    end
  end

  // FIFO models: head data valid the cycle after the pop edge
  always @(posedge clk) begin
    if (clk_enable) begin
      if (read0) begin
        rdata0 <= mem0[rp0[5:0]];
        rp0    <= rp0 + 1;
        if (empty0) viol <= viol + 1;
      end
      if (read1) begin
        rdata1 <= mem1[rp1[5:0]];
        rp1    <= rp1 + 1;
        if (empty1) viol <= viol + 1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input int sel, input logic [7:0] b);
    if (sel == 0) begin
      mem0[wp0[5:0]] = b;
      wp0++;
      sb0.push_back(b);
    end else begin
      mem1[wp1[5:0]] = b;
      wp1++;
      sb1.push_back(b);
    end
  endtask

  task automatic en_tick(output int raw);
    raw = 0;
    do begin
      @(posedge clk);
      raw++;
    end while (!clk_enable);
    #1;
  endtask

  task automatic wait_start(input int sel, output int waited);
    int r;
    waited = 0;
    do begin
      en_tick(r);
      waited++;
    end while (((sel != 0) ? tx1 : tx0) !== 1'b0 && waited < 300);
    chk("start_bit", {63'd0, ((sel != 0) ? tx1 : tx0)}, 64'd0);
  endtask

  task automatic capture(input int sel, input int exp_raw);
    logic [63:0] otx, ofd, etx, efd;
    logic [11:0] fr;
    logic [7:0]  b;
    int p, nb, flc, raw, r;
    p   = (sel != 0) ? 1 : 0;
    nb  = DW + 2 + p;
    flc = nb * CPB;
    b   = 8'h00;
    if (sel == 0) begin
      if (sb0.size() > 0) b = sb0.pop_front();
    end else begin
      if (sb1.size() > 0) b = sb1.pop_front();
    end
    fr = 12'd0;
    for (int i = 0; i < DW; i++) fr[1+i] = b[i];
    if (p == 1) fr[DW+1] = ^b;
    fr[nb-1] = 1'b1;
    etx = 64'd0;
    efd = 64'd0;
    for (int o = 0; o < flc; o++) etx[o] = fr[o/CPB];
    efd[flc-1] = 1'b1;
    otx = 64'd0;
    ofd = 64'd0;
    raw = 0;
    for (int o = 0; o < flc; o++) begin
      if (o > 0) begin
        en_tick(r);
        raw += r;
      end
      otx[o] = (sel != 0) ? tx1 : tx0;
      ofd[o] = (sel != 0) ? fd1 : fd0;
    end
    chk("frame_tx", otx, etx);
    chk("frame_done", ofd, efd);
    chk("frame_cycles", 64'(raw), 64'(exp_raw));
  endtask

  task automatic frame(input int sel, input bit chk_gap, input int exp_raw);
    int w;
    wait_start(sel, w);
    if (chk_gap) chk("gap_cycles", 64'(w), 64'd3);
    capture(sel, exp_raw);
  endtask

  initial begin
    int r, w;
    // Reset held with data available
    repeat (2) @(negedge clk);
    push(0, 8'hA5);
    repeat (2) @(negedge clk);
    chk("rst_tx", {63'd0, tx0}, 64'd1);
    chk("rst_read", {63'd0, read0}, 64'd0);
    chk("rst_busy", {63'd0, busy0}, 64'd0);
    chk("rst_fd", {63'd0, fd0}, 64'd0);
    chk("rst_tx_p", {63'd0, tx1}, 64'd1);
    rst_n = 1'b1;
    en_tick(r);
    chk("first_pop", {63'd0, read0}, 64'd1);
    frame(0, 1'b0, 39);
    repeat (2) en_tick(r);
    chk("idle_busy", {63'd0, busy0}, 64'd0);
    chk("pops_a5", 64'(rp0), 64'd1);

    // Even parity: A5 -> 0, 07 -> 1
    @(negedge clk);
    push(1, 8'hA5);
    push(1, 8'h07);
    frame(1, 1'b0, 43);
    frame(1, 1'b1, 43);
    repeat (2) en_tick(r);
    chk("par_busy", {63'd0, busy1}, 64'd0);
    chk("par_pops", 64'(rp1), 64'd2);

    // Back-to-back frames
    @(negedge clk);
    push(0, 8'h00);
    push(0, 8'h11);
    push(0, 8'h22);
    frame(0, 1'b0, 39);
    frame(0, 1'b1, 39);
    frame(0, 1'b1, 39);
    repeat (3) en_tick(r);
    chk("b2b_busy", {63'd0, busy0}, 64'd0);
    chk("b2b_pops", 64'(rp0), 64'd4);

    // clk_enable toggling doubles every duration
    @(negedge clk);
    toggle = 1'b1;
    push(0, 8'h3C);
    frame(0, 1'b0, 78);
    toggle = 1'b0;
    repeat (3) en_tick(r);
    chk("ce_pops", 64'(rp0), 64'd5);
    chk("ce_busy", {63'd0, busy0}, 64'd0);

    // Reset during third data bit
    @(negedge clk);
    push(0, 8'h5A);
    push(0, 8'hC3);
    wait_start(0, w);
    repeat (13) en_tick(r);
    chk("pre_rst_tx", {63'd0, tx0}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", {63'd0, tx0}, 64'd1);
    chk("async_rst_busy", {63'd0, busy0}, 64'd0);
    chk("async_rst_read", {63'd0, read0}, 64'd0);
    void'(sb0.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    frame(0, 1'b0, 39);
    chk("rst_pops", 64'(rp0), 64'd7);

    // tx_enable dropped mid-frame
    @(negedge clk);
    push(0, 8'h81);
    push(0, 8'h42);
    wait_start(0, w);
    tx_enable = 1'b0;
    capture(0, 39);
    repeat (20) en_tick(r);
    chk("txen_tx", {63'd0, tx0}, 64'd1);
    chk("txen_busy", {63'd0, busy0}, 64'd0);
    chk("txen_pops", 64'(rp0), 64'd8);
    chk("no_empty_pop", 64'(viol), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
